// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM state type and default link constants
// used by uart_tx, uart_rx and uart_tick_generator.
package uart_pkg;

  localparam int unsigned SampleRateDefault = 16;
  localparam int unsigned BaudDefault       = 115200;
  localparam int unsigned ClkHzDefault      = 100_000_000;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_holding.sv
// One-entry valid/ready holding register in front of the uart_tx shifter.
// Loads on handshake, empties when the transmitter takes the byte.
module uart_tx_holding #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             take_i,
  output logic             full_o,
  output logic [Width-1:0] data_o
);

  logic             full_d, full_q;
  logic [Width-1:0] data_d, data_q;

  // load and take are mutually exclusive: load needs empty, take needs full
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (take_i) begin
      full_d = 1'b0;
    end
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS payload LSB first, STOP_BITS stop bits, paced by tick_in.
// Define UART_TX_PARITY_EN to insert a parity bit after the data (PARITY_ODD selects odd parity).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned SAMPLE_RATE = SampleRateDefault,
  parameter int unsigned DATA_BITS   = 8,
`ifdef UART_TX_PARITY_EN
  parameter int unsigned STOP_BITS   = 1,
  parameter bit          PARITY_ODD  = 1'b0
`else
  parameter int unsigned STOP_BITS   = 1
`endif
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 tick_in,
  input  logic                 enable_in,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic                 tx_out,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int unsigned      TickW    = $clog2(SAMPLE_RATE);
  localparam int unsigned      BitW     = $clog2(DATA_BITS + 1);
  localparam logic [TickW-1:0] TickLast = TickW'(SAMPLE_RATE - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

  uart_tx_state_t       state_d, state_q;
  logic [TickW-1:0]     tick_cnt_d, tick_cnt_q;
  logic [BitW-1:0]      bit_cnt_d, bit_cnt_q;
  logic [DATA_BITS-1:0] shift_d, shift_q;
  logic                 tx_d, tx_q;
  logic                 busy_d, busy_q;
  logic                 done_d, done_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_d, parity_q;
`endif

  logic                 hold_full;
  logic                 hold_load;
  logic                 hold_take;
  logic [DATA_BITS-1:0] hold_data;
  logic                 bit_end;
  logic                 launch;

  assign ready_out = ~hold_full;
  assign hold_load = valid_in & ~hold_full;

  uart_tx_holding #(
    .Width (DATA_BITS)
  ) u_holding (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .load_i (hold_load),
    .data_i (data_in),
    .take_i (hold_take),
    .full_o (hold_full),
    .data_o (hold_data)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    hold_take  = 1'b0;
    launch     = 1'b0;
    bit_end    = tick_in && (tick_cnt_q == TickLast);

    if (tick_in && (state_q != StIdle)) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        launch = tick_in && hold_full && enable_in;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = StParity;
            tx_d      = parity_q;
`else
            state_d   = StStop;
            tx_d      = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        // bit_cnt counts stop-bit periods here
        if (bit_end) begin
          if (bit_cnt_q == StopLast) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            if (hold_full && enable_in) begin
              launch = 1'b1;
            end else begin
              state_d = StIdle;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Copy the held byte into the shifter; start bit goes out from the next cycle
    if (launch) begin
      hold_take  = 1'b1;
      shift_d    = hold_data;
      state_d    = StStart;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
      parity_d   = (^hold_data) ^ PARITY_ODD;
`endif
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx_out   = tx_q;
  assign busy_out = busy_q;
  assign done_out = done_q;

endmodule
